// File: rtl/mem_bus_arbiter.sv
// Two-master (IF read-only, MEM read/write) arbiter onto a single memory bus,
// one transaction outstanding, with pipeline stall levels and IF flush support.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no transaction; arbitrate and register winner onto bus_*
// S_ADDR | bus_req_o high, holding bus_* until bus_req_ready_i
// S_RESP | waiting for rvalid (read) or bvalid (write) from the slave
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_rvalid_o,
  output logic                if_stall_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_done_o,
  output logic                mem_stall_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_req_ready_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_bvalid_i
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   drop;

  logic if_ok;
  logic mem_ok;
  logic grant_mem;
  logic grant_if;
  logic resp_hit;

  // A requester whose done pulse is high this cycle is still consuming data.
  always_comb begin
    if_ok     = if_req_i & ~if_flush_i & ~if_rvalid_o;
    mem_ok    = mem_req_i & ~mem_done_o;
    grant_mem = mem_ok & ~(if_ok & (last_grant == OWN_MEM));
    grant_if  = if_ok & ~grant_mem;
    resp_hit  = bus_we_o ? bus_bvalid_i : bus_rvalid_i;
  end

  // Stalls are gated by reset so they fall immediately on an async reset.
  always_comb begin
    if_stall_o  = rst_n & if_req_i & ~if_rvalid_o;
    mem_stall_o = rst_n & mem_req_i & ~mem_done_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= OWN_IF;
      last_grant  <= OWN_IF;
      drop        <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
      if_rdata_o  <= '0;
      if_rvalid_o <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
    end else begin
      if_rvalid_o <= 1'b0;
      mem_done_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_mem || grant_if) begin
            owner      <= grant_mem;
            last_grant <= grant_mem;
            bus_req_o  <= 1'b1;
            state      <= S_ADDR;
            if (grant_mem) begin
              bus_we_o    <= mem_we_i;
              bus_addr_o  <= mem_addr_i;
              bus_wdata_o <= mem_wdata_i;
              bus_wstrb_o <= mem_wstrb_i;
            end else begin
              bus_we_o    <= 1'b0;
              bus_addr_o  <= if_addr_i;
              bus_wdata_o <= '0;
              bus_wstrb_o <= '0;
            end
          end
        end
        S_ADDR: begin
          if (owner == OWN_IF && if_flush_i) drop <= 1'b1;
          if (bus_req_ready_i) begin
            bus_req_o <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (owner == OWN_IF && if_flush_i) drop <= 1'b1;
          if (resp_hit) begin
            state <= S_IDLE;
            drop  <= 1'b0;
            if (owner == OWN_MEM) begin
              mem_done_o <= 1'b1;
              if (!bus_we_o) mem_rdata_o <= bus_rdata_i;
            end else if (!(drop || if_flush_i)) begin
              // a flush landing on the response cycle also discards the data
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= bus_rdata_i;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
